// File: rtl/rd_defs_pkg.sv
// Shared definitions for the recursive-doubling subtractor: default width,
// prefix-level derivation, G/P bundle type and pipeline stage count.
package rd_defs;

    localparam int WIDTH_DEF  = 32;
    localparam int LEVELS_DEF = $clog2(WIDTH_DEF);
    localparam int S_DEF      = LEVELS_DEF + 2;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] g;
        logic [WIDTH_DEF-1:0] p;
    } gp_t;

    // One input register stage, one stage per prefix level, one output stage.
    function automatic int stage_count(input int width);
        return $clog2(width) + 2;
    endfunction

endpackage

// File: rtl/rd_prefix_level.sv
// One Kogge-Stone prefix level: combines each bit's group G/P with the group
// DIST positions below it; the lowest DIST bits pass through unchanged.
module rd_prefix_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= DIST) begin : g_comb
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
                assign p_out[i] = p_in[i] & p_in[i-DIST];
            end else begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    endgenerate

endmodule

// File: rtl/rd_subtractor.sv
// Pipelined Kogge-Stone subtractor (a - b - bin) with borrow-out, signed
// overflow and a valid/ready handshake; every stage advances or holds together.
module rd_subtractor
    import rd_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int S      = stage_count(WIDTH);

    logic             stall;
    logic             c0;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] g_st1;
    logic [WIDTH-1:0] p_st1;
    logic [WIDTH-1:0] po_st1;

    logic [WIDTH-1:0] g_q  [0:LEVELS];
    logic [WIDTH-1:0] p_q  [0:LEVELS];
    logic [WIDTH-1:0] po_q [0:LEVELS];
    logic [LEVELS:0]  c0_q;
    logic [LEVELS:0]  am_q;
    logic [LEVELS:0]  bm_q;
    logic [S-1:0]     v_q;

    logic [WIDTH-1:0] g_nx [1:LEVELS];
    logic [WIDTH-1:0] p_nx [1:LEVELS];

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_nx;
    logic             bout_nx;
    logic             ovf_nx;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[S-1];

    // Subtraction as a + ~b + ~bin; the carry-in is merged into bit 0 so the
    // prefix network only has to span WIDTH positions.
    always_comb begin
        nb       = ~b;
        c0       = ~bin;
        po_st1   = a ^ nb;
        g_st1    = a & nb;
        g_st1[0] = g_st1[0] | (po_st1[0] & c0);
        p_st1    = po_st1;
        p_st1[0] = 1'b0;
    end

    genvar k;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_level
            rd_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (k - 1))
            ) u_level (
                .g_in  (g_q[k-1]),
                .p_in  (p_q[k-1]),
                .g_out (g_nx[k]),
                .p_out (p_nx[k])
            );
        end
    endgenerate

    always_comb begin
        carry   = {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};
        diff_nx = po_q[LEVELS] ^ carry;
        bout_nx = ~g_q[LEVELS][WIDTH-1];
        ovf_nx  = (am_q[LEVELS] ^ bm_q[LEVELS]) & (am_q[LEVELS] ^ diff_nx[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= LEVELS; j++) begin
                g_q[j]  <= '0;
                p_q[j]  <= '0;
                po_q[j] <= '0;
            end
            c0_q <= '0;
            am_q <= '0;
            bm_q <= '0;
            v_q  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (!stall) begin
            g_q[0]  <= g_st1;
            p_q[0]  <= p_st1;
            po_q[0] <= po_st1;
            for (int j = 1; j <= LEVELS; j++) begin
                g_q[j]  <= g_nx[j];
                p_q[j]  <= p_nx[j];
                po_q[j] <= po_q[j-1];
            end
            c0_q <= {c0_q[LEVELS-1:0], c0};
            am_q <= {am_q[LEVELS-1:0], a[WIDTH-1]};
            bm_q <= {bm_q[LEVELS-1:0], b[WIDTH-1]};
            v_q  <= {v_q[S-2:0], in_valid};
            diff <= diff_nx;
            bout <= bout_nx;
            ovf  <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_rd_subtractor.sv
// Directed bench for rd_subtractor: fixed vectors, back-to-back stream,
// output stall with backpressure, and mid-flight reset.
module tb_rd_subtractor;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    rd_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Independent arithmetic reference: 33-bit unsigned difference.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        exp_t e;
        r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ r[W-1]);
        return e;
    endfunction

    task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        bin      = c;
    endtask

    task automatic run_directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input logic [W-1:0] ed, input logic eb, input logic eo);
        apply_stimulus(x, y, c);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEADBEEF;
        b        = 32'h12345678;
        repeat (5) @(negedge clk);
        check_output({tag, " early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_output({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check_output({tag, " diff"}, diff, ed);
        check_output({tag, " bout"}, {31'd0, bout}, {31'd0, eb});
        check_output({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    initial begin
        exp_t         e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        int           sent;
        int           got;
        int           first_cyc;
        int           last_cyc;
        int           acc;
        int           stale;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #1;
        check_output("reset out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset diff", diff, 32'd0);
        check_output("reset bout", {31'd0, bout}, 32'd0);
        check_output("reset ovf", {31'd0, ovf}, 32'd0);
        check_output("reset in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        run_directed("vec1", 32'h20430003, 32'h0901800C, 1'b0, 32'h17417FF7, 1'b0, 1'b0);
        run_directed("zero-1", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_directed("5-5-1", 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_directed("minneg-1", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_directed("maxpos-m1", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);

        $display("[TB] back-to-back stream");
        sent      = 0;
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_output("stream unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_output("stream diff", diff, e.d);
                    check_output("stream bout", {31'd0, bout}, {31'd0, e.bo});
                    check_output("stream ovf", {31'd0, ovf}, {31'd0, e.ov});
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (sent < 20) begin
                x        = $urandom;
                y        = $urandom;
                c        = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                a        = x;
                b        = y;
                bin      = c;
                q.push_back(model(x, y, c));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_output("stream count", got, 32'd20);
        check_output("stream spacing", last_cyc - first_cyc, 32'd19);
        q.delete();

        $display("[TB] output stall");
        @(negedge clk);
        out_ready = 1'b0;
        acc       = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (in_ready) begin
                x        = $urandom;
                y        = $urandom;
                c        = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                a        = x;
                b        = y;
                bin      = c;
                q.push_back(model(x, y, c));
                acc++;
            end
            @(negedge clk);
        end
        check_output("stall accepted", acc, 32'd7);
        check_output("stall in_ready", {31'd0, in_ready}, 32'd0);
        check_output("stall out_valid", {31'd0, out_valid}, 32'd1);
        check_output("stall frozen diff", diff, q[0].d);
        check_output("stall frozen bout", {31'd0, bout}, {31'd0, q[0].bo});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got       = 0;
        for (int cyc = 0; cyc < 20 && got < 7; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_output("drain unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_output("drain diff", diff, e.d);
                    check_output("drain ovf", {31'd0, ovf}, {31'd0, e.ov});
                end
                got++;
            end
            @(negedge clk);
        end
        check_output("drain count", got, 32'd7);
        check_output("drain leftover", q.size(), 32'd0);

        $display("[TB] reset with results in flight");
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(32'h00001000 + i * 32'h111, 32'h00000001, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_output("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
        check_output("mid-reset diff", diff, 32'd0);
        check_output("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check_output("stale results", stale, 32'd0);
        run_directed("post-reset", 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
